// File: rtl/descr_pkg.sv
// Shared constants and FSM state type for the descrambler/deframer.
// Descrambler polynomial is x^12+x^9+x^2+1, matching the upstream serial scrambler.
package descr_pkg;

   localparam int LFSR_LEN = 12;
   localparam int TAP_A    = 1;
   localparam int TAP_B    = 8;
   localparam int TAP_C    = 11;

   typedef enum logic [1:0] {
      HUNT,
      CONFIRM,
      LOCK
   } state_t;

endpackage

// File: rtl/descrambler_core.sv
// Self-synchronising serial descrambler: history of received bits XORed with the taps.
// Recovered bit is combinational, so it is valid in the same cycle as data_i.
module descrambler_core
   import descr_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic data_i,
   output logic bit_o
);

   logic [LFSR_LEN-1:0] hist;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist <= '0;
      end else begin
         hist <= {hist[LFSR_LEN-2:0], data_i};
      end
   end

   assign bit_o = data_i ^ hist[TAP_A] ^ hist[TAP_B] ^ hist[TAP_C];

endmodule

// File: rtl/descrambler_deframer.sv
// Descrambles the serial stream, hunts/confirms sync alignment and emits payload bytes.
// Optional statistics counters are built when FRAME_STATS_EN is defined.
module descrambler_deframer
   import descr_pkg::*;
#(
   parameter int                SYNC_W    = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA7,
   parameter int                FRAME_LEN = 4,
   parameter int                LOCK_CNT  = 2,
   parameter int                LOSS_CNT  = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_i,
   output logic [7:0]  data_o,
   output logic        valid_o,
   output logic        sof_o,
   output logic        lock_o
`ifdef FRAME_STATS_EN
   ,
   output logic [15:0] frame_cnt_o,
   output logic [15:0] sync_err_cnt_o
`endif
);

   localparam int PAY_BITS   = 8 * FRAME_LEN;
   localparam int FRAME_BITS = PAY_BITS + SYNC_W;
   localparam int CNT_W      = $clog2(FRAME_BITS);
   localparam int GOOD_W     = $clog2(LOCK_CNT + 1);
   localparam int MISS_W     = $clog2(LOSS_CNT + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]  PAY_END  = CNT_W'(PAY_BITS);
   localparam logic [CNT_W-1:0]  BYTE0_END = CNT_W'(7);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
   localparam logic [MISS_W-1:0] LOSS_MAX = MISS_W'(LOSS_CNT);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic [MISS_W-1:0]   miss_q, miss_d;
   logic [SYNC_W-1:0]   win_q, win_d;
   logic [6:0]          byte_q;
   logic [7:0]          byte_d;
   logic                d_bit;
   logic                match;
   logic                at_check;
   logic                emit;
   logic                emit_sof;

   descrambler_core u_core (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .data_i (data_i),
      .bit_o  (d_bit)
   );

   // The sync test sees the window including the bit sampled on this edge.
   if (SYNC_W == 1) begin : g_win1
      assign win_d = d_bit;
   end else begin : g_winn
      assign win_d = {win_q[SYNC_W-2:0], d_bit};
   end

   assign byte_d   = {byte_q, d_bit};
   assign match    = (win_d == SYNC_WORD);
   assign at_check = (bit_cnt_q == LAST_BIT);
   assign lock_o   = (state_q == LOCK);

   // NOTE: every signal written here gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = at_check ? '0 : bit_cnt_q + 1'b1;
      good_d    = good_q;
      miss_d    = miss_q;
      emit      = 1'b0;
      emit_sof  = 1'b0;

      unique case (state_q)
         HUNT: begin
            bit_cnt_d = '0;
            if (match) begin
               good_d  = GOOD_W'(1);
               miss_d  = '0;
               state_d = (LOCK_CNT == 1) ? LOCK : CONFIRM;
            end
         end
         CONFIRM: begin
            if (at_check) begin
               if (match) begin
                  good_d = good_q + 1'b1;
                  miss_d = '0;
                  if (good_q + 1'b1 == GOOD_MAX) state_d = LOCK;
               end else begin
                  state_d = HUNT;
               end
            end
         end
         LOCK: begin
            if (at_check) begin
               if (match) begin
                  miss_d = '0;
               end else begin
                  // Flywheel: alignment is kept until LOSS_CNT consecutive misses.
                  miss_d = miss_q + 1'b1;
                  if (miss_q + 1'b1 == LOSS_MAX) state_d = HUNT;
               end
            end else if (bit_cnt_q < PAY_END && bit_cnt_q[2:0] == 3'd7) begin
               emit     = 1'b1;
               emit_sof = (bit_cnt_q == BYTE0_END);
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= HUNT;
         bit_cnt_q <= '0;
         good_q    <= '0;
         miss_q    <= '0;
         win_q     <= '0;
         byte_q    <= '0;
         data_o    <= '0;
         valid_o   <= 1'b0;
         sof_o     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         good_q    <= good_d;
         miss_q    <= miss_d;
         win_q     <= win_d;
         byte_q    <= byte_d[6:0];
         valid_o   <= emit;
         sof_o     <= emit_sof;
         if (emit) data_o <= byte_d;
      end
   end

`ifdef FRAME_STATS_EN
   logic good_sync;
   logic bad_sync;

   assign good_sync = (state_q == LOCK) && at_check && match;
   assign bad_sync  = (state_q == LOCK) && at_check && !match;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt_o    <= '0;
         sync_err_cnt_o <= '0;
      end else begin
         if (good_sync && frame_cnt_o != 16'hFFFF) frame_cnt_o <= frame_cnt_o + 1'b1;
         if (bad_sync && sync_err_cnt_o != 16'hFFFF) sync_err_cnt_o <= sync_err_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_descrambler_deframer.sv
// Bench: scrambles known frames, drives the deframer and compares against a frame-level model.
// Statistics outputs are checked when FRAME_STATS_EN is defined.
module tb_descrambler_deframer;

   localparam int         SYNC_W     = 8;
   localparam logic [7:0] SYNC_WORD  = 8'hA7;
   localparam logic [7:0] BAD_SYNC   = 8'hA6;
   localparam int         FRAME_LEN  = 4;
   localparam int         LOCK_CNT   = 2;
   localparam int         LOSS_CNT   = 3;
   localparam int         FRAME_BITS = 8 * FRAME_LEN + SYNC_W;

   typedef enum {M_HUNT, M_CONFIRM, M_LOCK} mode_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        data_i;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        sof_o;
   logic        lock_o;
`ifdef FRAME_STATS_EN
   logic [15:0] frame_cnt_o;
   logic [15:0] sync_err_cnt_o;
`endif

   descrambler_deframer #(
      .SYNC_W    (SYNC_W),
      .SYNC_WORD (SYNC_WORD),
      .FRAME_LEN (FRAME_LEN),
      .LOCK_CNT  (LOCK_CNT),
      .LOSS_CNT  (LOSS_CNT)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .data_i         (data_i),
      .data_o         (data_o),
      .valid_o        (valid_o),
      .sof_o          (sof_o),
      .lock_o         (lock_o)
`ifdef FRAME_STATS_EN
      ,
      .frame_cnt_o    (frame_cnt_o),
      .sync_err_cnt_o (sync_err_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int total;
   int bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Upstream scrambler, independent of the DUT's reset.
   logic [11:0] scr;

   // Frame-level reference model, indexed by absolute bit time since reset.
   bit         rxq[$];
   bit         dq[$];
   mode_t      m_mode;
   int         m_good, m_miss, m_t, m_sync_t;
   int         m_frames, m_errs;
   logic [7:0] m_data;
   logic       m_valid, m_sof;

   task automatic model_step(input bit rst, input bit rx);
      bit         d;
      bit         match;
      int         n, k, idx;
      logic [7:0] w;
      logic [7:0] b;
      if (rst) begin
         rxq = {};
         repeat (12) rxq.push_back(1'b0);
         dq = {};
         m_mode = M_HUNT;
         m_good = 0; m_miss = 0; m_t = 0; m_sync_t = 0;
         m_frames = 0; m_errs = 0;
         m_data = '0; m_valid = 1'b0; m_sof = 1'b0;
         return;
      end
      m_t++;
      n = rxq.size();
      d = rx ^ rxq[n-2] ^ rxq[n-9] ^ rxq[n-12];
      rxq.push_back(rx);
      void'(rxq.pop_front());
      dq.push_back(d);
      if (dq.size() > 16) void'(dq.pop_front());
      w = '0;
      for (int i = 0; i < SYNC_W; i++) begin
         idx = dq.size() - SYNC_W + i;
         w = (w << 1) | ((idx >= 0) ? 8'(dq[idx]) : 8'h00);
      end
      match = (w == SYNC_WORD);
      m_valid = 1'b0;
      m_sof   = 1'b0;
      if (m_mode == M_HUNT) begin
         if (match) begin
            m_mode   = (LOCK_CNT == 1) ? M_LOCK : M_CONFIRM;
            m_good   = 1;
            m_miss   = 0;
            m_sync_t = m_t;
         end
      end else begin
         k = m_t - m_sync_t - 1;
         if (k == FRAME_BITS - 1) begin
            m_sync_t = m_t;
            if (m_mode == M_CONFIRM) begin
               if (match) begin
                  m_good++;
                  if (m_good == LOCK_CNT) begin
                     m_mode = M_LOCK;
                     m_miss = 0;
                  end
               end else begin
                  m_mode = M_HUNT;
               end
            end else if (match) begin
               m_miss = 0;
               m_frames++;
            end else begin
               m_miss++;
               m_errs++;
               if (m_miss == LOSS_CNT) m_mode = M_HUNT;
            end
         end else if (m_mode == M_LOCK && k < 8 * FRAME_LEN && k % 8 == 7) begin
            b = '0;
            for (int i = 8; i >= 1; i--) b = {b[6:0], dq[dq.size() - i]};
            m_data  = b;
            m_valid = 1'b1;
            m_sof   = (k == 7);
         end
      end
   endtask

   task automatic step(input bit p, input bit rst);
      bit s;
      s      = p ^ scr[1] ^ scr[8] ^ scr[11];
      scr    = {scr[10:0], s};
      data_i = s;
      rst_i  = rst;
      @(posedge clk_i);
      model_step(rst, s);
      #1;
      check("valid", 32'(valid_o), 32'(m_valid));
      check("sof", 32'(sof_o), 32'(m_sof));
      check("data", 32'(data_o), 32'(m_data));
      check("lock", 32'(lock_o), 32'(m_mode == M_LOCK));
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) step(b[i], 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] sync, input logic [31:0] payload);
      send_byte(sync);
      for (int i = 3; i >= 0; i--) send_byte(payload[8*i +: 8]);
   endtask

   task automatic reset_both();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      scr = '0;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      data_i = 1'b0;
      rst_i  = 1'b1;
      scr    = '0;

      // Reset state
      reset_both();
      check("rst_lock", 32'(lock_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);

      // Aligned scrambler and DUT, fixed frames
      send_frame(SYNC_WORD, 32'h01020304);
      check("p1_lock_after_sync1", 32'(lock_o), 32'd0);
      send_byte(SYNC_WORD);
      check("p1_lock_after_sync2", 32'(lock_o), 32'd1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      repeat (4) send_frame(SYNC_WORD, 32'h01020304);

      // DUT comes out of reset 50 bits after the scrambler
      scr = '0;
      repeat (50) step(1'($urandom_range(0, 1)), 1'b1);
      repeat (6) send_frame(SYNC_WORD, 32'h01020304);
      check("p2_locked", 32'(lock_o), 32'd1);

      // Single bad sync is bridged, three in a row drop lock
      send_frame(BAD_SYNC, 32'h01020304);
      check("p3_flywheel", 32'(lock_o), 32'd1);
      repeat (2) send_frame(SYNC_WORD, 32'h01020304);
      send_frame(BAD_SYNC, 32'h11223344);
      send_frame(BAD_SYNC, 32'h55667788);
      send_byte(BAD_SYNC);
      check("p3_lost", 32'(lock_o), 32'd0);
      send_byte(8'h99); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      repeat (3) send_frame(SYNC_WORD, 32'h01020304);

      // False sync at a wrong offset during hunt
      reset_both();
      send_byte(8'h00); send_byte(SYNC_WORD); send_byte(8'h55);
      repeat (5) send_frame(SYNC_WORD, 32'h01020304);
      check("p4_relock", 32'(lock_o), 32'd1);

      // Reset pulse three bits into a locked byte
      send_byte(SYNC_WORD);
      send_byte(8'h01);
      step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("p5_lock_after_rst", 32'(lock_o), 32'd0);
      check("p5_valid_after_rst", 32'(valid_o), 32'd0);
      repeat (5) step(1'b0, 1'b0);
      send_byte(8'h03); send_byte(8'h04);
      repeat (5) send_frame(SYNC_WORD, 32'h01020304);
      check("p5_relock", 32'(lock_o), 32'd1);

      // Ten good frames then three bad syncs
      reset_both();
      repeat (10) send_frame(SYNC_WORD, 32'h01020304);
      repeat (3) send_frame(BAD_SYNC, 32'h01020304);
      check("p6_lost", 32'(lock_o), 32'd0);
`ifdef FRAME_STATS_EN
      check("p6_frame_cnt", 32'(frame_cnt_o), 32'(10 - LOCK_CNT));
      check("p6_err_cnt", 32'(sync_err_cnt_o), 32'd3);
      check("p6_frame_cnt_model", 32'(frame_cnt_o), 32'(m_frames));
`endif

      // Randomised frames, corruption, slips and reset pulses
      reset_both();
      for (int f = 0; f < 60; f++) begin
         if ($urandom_range(0, 7) == 0)
            repeat ($urandom_range(1, 20)) step(1'($urandom_range(0, 1)), 1'b0);
         if ($urandom_range(0, 29) == 0) step(1'b0, 1'b1);
         send_frame(($urandom_range(0, 4) == 0) ? 8'(SYNC_WORD ^ (8'h01 << $urandom_range(0, 7)))
                                                 : SYNC_WORD,
                    32'($urandom()));
      end
`ifdef FRAME_STATS_EN
      check("rand_frame_cnt", 32'(frame_cnt_o), 32'(m_frames));
      check("rand_err_cnt", 32'(sync_err_cnt_o), 32'(m_errs));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
